// File: rtl/dcache_dm.sv
// Direct-mapped, write-back data cache with two-word blocks.
// Hits complete combinationally in IDLE; misses and halt-time flushes run a word-serial memory handshake.
module dcache_dm #(
    parameter int unsigned SETS     = 16,
    parameter int unsigned BLKWORDS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload
);

    localparam int unsigned IDXW = $clog2(SETS);
    localparam int unsigned TAGW = 32 - 3 - IDXW;

    typedef enum logic [3:0] {
        IDLE, WB0, WB1, FETCH0, FETCH1, FLUSH, FLUSHWB0, FLUSHWB1, DONE
    } state_t;

    state_t state_q, state_d;

    logic [SETS-1:0] valid_q, dirty_q;
    logic [TAGW-1:0] tag_q  [SETS];
    logic [31:0]     data_q [SETS][BLKWORDS];
    logic [IDXW-1:0] cnt_q;

    logic [IDXW-1:0] req_idx;
    logic [TAGW-1:0] req_tag;
    logic            req_word;
    logic            req_c;
    logic            hit_c;
    logic            unused_addr_bits;

    // control strobes from the next-state logic
    logic wr_hit, fill0, fill1, flush_clr, cnt_inc, cnt_clr;

    assign req_idx          = dmemaddr[2+IDXW:3];
    assign req_tag          = dmemaddr[31:3+IDXW];
    assign req_word         = dmemaddr[2];
    assign req_c            = dmemREN | dmemWEN;
    assign hit_c            = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign unused_addr_bits = ^dmemaddr[1:0];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (cnt_clr)
                cnt_q <= '0;
            else if (cnt_inc)
                cnt_q <= cnt_q + IDXW'(1);
            if (fill1) begin
                valid_q[req_idx] <= 1'b1;
                dirty_q[req_idx] <= 1'b0;
            end
            if (wr_hit)
                dirty_q[req_idx] <= 1'b1;
            if (flush_clr)
                dirty_q[cnt_q] <= 1'b0;
        end
    end

    // tag/data arrays carry no reset; valid bits gate their use
    always_ff @(posedge CLK) begin
        if (fill0)
            data_q[req_idx][0] <= dload;
        if (fill1) begin
            data_q[req_idx][1] <= dload;
            tag_q[req_idx]     <= req_tag;
        end
        if (wr_hit)
            data_q[req_idx][req_word] <= dmemstore;
    end

    always_comb begin
        state_d   = state_q;
        dhit      = 1'b0;
        dmemload  = '0;
        flushed   = 1'b0;
        dREN      = 1'b0;
        dWEN      = 1'b0;
        daddr     = '0;
        dstore    = '0;
        wr_hit    = 1'b0;
        fill0     = 1'b0;
        fill1     = 1'b0;
        flush_clr = 1'b0;
        cnt_inc   = 1'b0;
        cnt_clr   = 1'b0;

        case (state_q)
            IDLE: begin
                if (halt) begin
                    state_d = FLUSH;
                    cnt_clr = 1'b1;
                end else if (req_c) begin
                    if (hit_c) begin
                        dhit     = 1'b1;
                        dmemload = data_q[req_idx][req_word];
                        wr_hit   = dmemWEN;
                    end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
                        state_d = WB0;
                    end else begin
                        state_d = FETCH0;
                    end
                end
            end
            WB0: begin
                dWEN   = 1'b1;
                daddr  = {tag_q[req_idx], req_idx, 1'b0, 2'b00};
                dstore = data_q[req_idx][0];
                if (!dwait) state_d = WB1;
            end
            WB1: begin
                dWEN   = 1'b1;
                daddr  = {tag_q[req_idx], req_idx, 1'b1, 2'b00};
                dstore = data_q[req_idx][1];
                if (!dwait) state_d = FETCH0;
            end
            FETCH0: begin
                dREN  = 1'b1;
                daddr = {req_tag, req_idx, 1'b0, 2'b00};
                if (!dwait) begin
                    state_d = FETCH1;
                    fill0   = 1'b1;
                end
            end
            FETCH1: begin
                dREN  = 1'b1;
                daddr = {req_tag, req_idx, 1'b1, 2'b00};
                if (!dwait) begin
                    state_d = IDLE;
                    fill1   = 1'b1;
                end
            end
            FLUSH: begin
                if (valid_q[cnt_q] && dirty_q[cnt_q])
                    state_d = FLUSHWB0;
                else if (cnt_q == IDXW'(SETS - 1))
                    state_d = DONE;
                else
                    cnt_inc = 1'b1;
            end
            FLUSHWB0: begin
                dWEN   = 1'b1;
                daddr  = {tag_q[cnt_q], cnt_q, 1'b0, 2'b00};
                dstore = data_q[cnt_q][0];
                if (!dwait) state_d = FLUSHWB1;
            end
            FLUSHWB1: begin
                dWEN   = 1'b1;
                daddr  = {tag_q[cnt_q], cnt_q, 1'b1, 2'b00};
                dstore = data_q[cnt_q][1];
                if (!dwait) begin
                    state_d   = FLUSH;
                    flush_clr = 1'b1;
                end
            end
            DONE: begin
                flushed = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/dcache_dm.md
DCACHE_DM -- requirements
Module: dcache_dm

Interface
REQ-001 SHALL have parameter SETS, default 16, number of direct-mapped frames (power of two, 2..64).
REQ-002 SHALL have parameter BLKWORDS, fixed 2, words per block.
REQ-003 SHALL have port CLK  input  1  rising-edge clock.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port halt  input  1  processor halted; request flush of dirty data.
REQ-006 SHALL have port dmemREN  input  1  datapath load request.
REQ-007 SHALL have port dmemWEN  input  1  datapath store request.
REQ-008 SHALL have port dmemaddr  input  32  word-aligned load/store address.
REQ-009 SHALL have port dmemstore  input  32  store data.
REQ-010 SHALL have port dhit  output  1  request serviced this cycle.
REQ-011 SHALL have port dmemload  output  32  load data, valid while dhit=1.
REQ-012 SHALL have port flushed  output  1  flush complete; all dirty data in memory.
REQ-013 SHALL have port dREN  output  1  memory read request.
REQ-014 SHALL have port dWEN  output  1  memory write request.
REQ-015 SHALL have port daddr  output  32  memory word address.
REQ-016 SHALL have port dstore  output  32  memory write data.
REQ-017 SHALL have port dwait  input  1  memory busy; transfer completes on edge with dwait=0.
REQ-018 SHALL have port dload  input  32  memory read data, valid when dwait=0.

Function
REQ-019 SHALL decode dmemaddr: [1:0] ignored, [2] block word, [2+log2(SETS):3] index, remaining upper bits tag.
REQ-020 SHALL store per frame: valid, dirty, tag, 2 data words.
REQ-021 SHALL implement states IDLE, WB0, WB1, FETCH0, FETCH1, FLUSH, FLUSHWB0, FLUSHWB1, DONE.
REQ-022 SHALL, in IDLE with (dmemREN|dmemWEN) and valid&tag match, assert dhit combinationally same cycle; dmemload = addressed word.
REQ-023 SHALL, on write hit, update addressed word and set dirty at that clock edge.
REQ-024 SHALL treat dmemREN and dmemWEN both high as a store.
REQ-025 SHALL, on miss with dirty victim, go IDLE->WB0->WB1->FETCH0->FETCH1; clean/invalid victim goes IDLE->FETCH0.
REQ-026 SHALL in WB0/WB1 drive dWEN=1, daddr={victim tag,index,word,00}, dstore=victim word; advance only on edge with dwait=0.
REQ-027 SHALL in FETCH0/FETCH1 drive dREN=1, daddr={req tag,index,word,00}; capture dload and advance only on edge with dwait=0.
REQ-028 SHALL on FETCH1 completion set valid=1, dirty=0, tag=req tag, return to IDLE; request then hits next cycle.
REQ-029 SHALL keep dhit=0 in every state other than IDLE.
REQ-030 SHALL hold dREN, dWEN, daddr, dstore stable while dwait=1; never assert dREN and dWEN together.
REQ-031 SHALL, when halt=1 in IDLE, ignore requests and enter FLUSH with set counter=0; halt during miss completes miss first.
REQ-032 SHALL in FLUSH: dirty frame -> FLUSHWB0->FLUSHWB1 (same handshake as REQ-026), clear dirty, return to FLUSH; clean frame skip in one cycle.
REQ-033 SHALL increment set counter after each frame; after frame SETS-1 go DONE.
REQ-034 SHALL in DONE assert flushed=1, all memory outputs 0, remain until reset.
REQ-035 SHALL, with dmemREN=dmemWEN=0 in IDLE, assert no memory request.

Reset
REQ-036 SHALL on nRST=0 immediately clear all valid/dirty bits, set state IDLE, set counter 0.
REQ-037 SHALL drive dhit, flushed, dREN, dWEN, daddr, dstore, dmemload to 0 during reset.
REQ-038 SHALL abandon any transfer in progress when reset asserts mid-operation.

Verification
REQ-039 Cold load 0x100, dwait=1 for 2 cycles per word, memory 0x100=0xAAAA0000/0x104=0xBBBB1111 -> two reads 0x100,0x104, then dhit=1, dmemload=0xAAAA0000; load 0x104 hits immediately.
REQ-040 Store 0x100=0x12345678 after fill -> dhit same cycle, no memory write; load 0x100 returns 0x12345678.
REQ-041 Dirty 0x100, then load conflicting 0x300 (SETS=16) -> writes 0x100,0x104 (old data), reads 0x300,0x304, then hit.
REQ-042 Dirty sets 0 and 5, halt=1 -> exactly four writes (set 0 then set 5), then flushed=1 held.
REQ-043 Reset asserted during FETCH0 with dwait=1 -> outputs 0 immediately; prior line misses after reset.
REQ-044 dmemREN=dmemWEN=1 on hit -> treated as store, dirty set, dhit=1.
